ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte to the keyboard
//  (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) using the open-drain

---
 rtl/ps2_pkg.sv | 11 +
 rtl/ps2_line_sync.sv | 26 ++
 rtl/ps2_host_tx.sv | 110 +++++++++++
 tb/tb_ps2_host_tx.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, command bytes and timing helper.
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, DONE, ERROR} ps2_state_t;
  localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
  localparam logic [7:0] PS2_ACK = 8'hFA;
  function automatic longint max3(input longint a, input longint b, input longint c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchroniser for the PS/2 clock and data pads plus a
// one-cycle strobe on each synchronised clock falling edge.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_clk,
  input  logic i_dat,
  output logic o_clk,
  output logic o_dat,
  output logic o_fall
);
  logic [2:0] r_clk;
  logic [1:0] r_dat;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk <= '1;
      r_dat <= '1;
    end else begin
      r_clk <= {r_clk[1:0], i_clk};
      r_dat <= {r_dat[0], i_dat};
    end
  end
  assign o_clk = r_clk[1];
  assign o_dat = r_dat[1];
  assign o_fall = r_clk[2] & ~r_clk[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte to a PS/2 device using the open-drain
// request-to-send sequence, reporting completion or timeout/no-ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int INHIBIT_US = 120,
  parameter int START_TO_MS = 15,
  parameter int FRAME_TO_MS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_byte,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);
  localparam longint INH_CYC = longint'(INHIBIT_US) * CLK_HZ / 1_000_000;
  localparam longint START_CYC = longint'(START_TO_MS) * CLK_HZ / 1000;
  localparam longint FRAME_CYC = longint'(FRAME_TO_MS) * CLK_HZ / 1000;
  localparam int CW = $clog2(max3(INH_CYC, START_CYC, FRAME_CYC) + 1);
  localparam logic [CW-1:0] INH_END = CW'(INH_CYC - 1);
  localparam logic [CW-1:0] START_END = CW'(START_CYC - 1);
  localparam logic [CW-1:0] FRAME_END = CW'(FRAME_CYC - 1);
  ps2_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0] r_n;
  logic [8:0] r_shift;
  logic w_clk, w_dat, w_fall, w_err;
  ps2_line_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .i_clk (ps2_clk_in),
    .i_dat (ps2_dat_in),
    .o_clk (w_clk),
    .o_dat (w_dat),
    .o_fall(w_fall)
  );
  // Frame window runs from the first fall to WAIT_IDLE exit, so the counter is
  // only cleared once the first fall is seen.
  assign w_err = (r_state == RTS && !w_fall && r_cnt == START_END)
    || ((r_state == SEND || r_state == ACK) && !w_fall && r_cnt == FRAME_END)
    || (r_state == ACK && w_fall && w_dat)
    || (r_state == WAIT_IDLE && !(w_clk && w_dat) && r_cnt == FRAME_END);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_n <= '0;
      r_shift <= '0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      tx_error <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (tx_start) begin
            r_shift <= {~^tx_byte, tx_byte};
            tx_busy <= 1'b1;
            ps2_clk_oe <= 1'b1;
            r_state <= INHIBIT;
          end
        end
        INHIBIT: if (r_cnt == INH_END) begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b1;
          r_n <= '0;
          r_cnt <= '0;
          r_state <= RTS;
        end
        RTS, SEND: if (w_fall) begin
          r_n <= r_n + 4'd1;
          ps2_dat_oe <= (r_n == 4'd9) ? 1'b0 : ~r_shift[0];
          r_shift <= r_shift >> 1;
          if (r_state == RTS) r_cnt <= '0;
          r_state <= (r_n == 4'd9) ? ACK : SEND;
        end
        ACK: if (w_fall && !w_dat) begin
          r_n <= r_n + 4'd1;
          r_state <= WAIT_IDLE;
        end
        WAIT_IDLE: if (w_clk && w_dat) begin
          tx_done <= 1'b1;
          r_state <= DONE;
        end
        default: begin
          tx_done <= 1'b0;
          tx_error <= 1'b0;
          tx_busy <= 1'b0;
          r_state <= IDLE;
        end
      endcase
      if (w_err) begin
        r_state <= ERROR;
        tx_error <= 1'b1;
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a behavioural PS/2 device and
// checks the emitted frame bits, timing and done/error pulses.
module tb_ps2_host_tx;
  import ps2_pkg::*;
  localparam int LOWC = 20;
  localparam int HIGHC = 20;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_start = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe;
  logic ps2_clk_in, ps2_dat_in;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt <= err_cnt + 1;
  end
  ps2_host_tx #(.CLK_HZ(1_000_000)) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_byte   (tx_byte),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );
  // Expected line values after falls 1..10: data LSB first, odd parity, stop.
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    logic [9:0] f;
    int ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = ((int'(b) / (1 << i)) % 2) == 1;
      ones += (int'(b) / (1 << i)) % 2;
    end
    f[8] = (ones % 2) == 0;
    f[9] = 1'b1;
    return f;
  endfunction
  task automatic device_frame(input bit ack, input int rst_fall, output logic [9:0] bits,
                              output logic [1:0] oe_rst, output bit ok);
    int t = 0;
    bits = '0;
    oe_rst = 2'b11;
    ok = 1'b1;
    while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      ok = 1'b0;
      return;
    end
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      if (k == rst_fall) begin
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        oe_rst = {ps2_clk_oe, ps2_dat_oe};
        dev_clk_low = 1'b0;
        return;
      end
      repeat (LOWC) @(negedge clk);
      if (k <= 10) bits[k-1] = ps2_dat_in;
      dev_clk_low = 1'b0;
      repeat (HIGHC / 2) @(negedge clk);
      if (k == 10 && ack) dev_dat_low = 1'b1;
      repeat (HIGHC / 2) @(negedge clk);
    end
    dev_dat_low = 1'b0;
  endtask
  task automatic run_frame(input logic [7:0] b, input bit ack, input int rst_fall,
                           input bit inject, input logic [7:0] b2, output logic [9:0] bits,
                           output int inh, output bit lat_ok, output logic [1:0] oe_rst,
                           output bit ok);
    int t = 0;
    @(negedge clk);
    tx_byte = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    lat_ok = ps2_clk_oe === 1'b1 && tx_busy === 1'b1;
    inh = 0;
    while (ps2_clk_oe === 1'b1 && inh < 1000) begin
      inh++;
      if (inject && inh == 5) begin
        tx_byte = b2;
        tx_start = 1'b1;
      end else tx_start = 1'b0;
      @(negedge clk);
    end
    tx_start = 1'b0;
    device_frame(ack, rst_fall, bits, oe_rst, ok);
    if (rst_fall == 0) begin
      while (tx_busy !== 1'b0 && t < 5000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 5000) ok = 1'b0;
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000",
               {tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe});
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask
  task automatic test_setled;
    logic [9:0] bits;
    logic [1:0] oe;
    int inh, d0, e0;
    bit lat, ok;
    d0 = done_cnt;
    e0 = err_cnt;
    run_frame(PS2_CMD_SETLED, 1'b1, 0, 1'b0, 8'h00, bits, inh, lat, oe, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL setled_ok: got timeout want completion"); end
    n_tests++;
    if (!lat) begin n_fail++; $display("FAIL setled_latency: got clk_oe/busy low want high 1 cycle after start"); end
    n_tests++;
    if (inh != 120) begin n_fail++; $display("FAIL setled_inhibit: got %0d want 120 cycles", inh); end
    n_tests++;
    if (bits !== model_frame(PS2_CMD_SETLED)) begin
      n_fail++;
      $display("FAIL setled_bits: got %b want %b", bits, model_frame(PS2_CMD_SETLED));
    end
    n_tests++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      n_fail++;
      $display("FAIL setled_pulses: got done=%0d err=%0d want 1/0", done_cnt - d0, err_cnt - e0);
    end
    n_tests++;
    if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin
      n_fail++;
      $display("FAIL setled_release: got oe=%b want 00", {ps2_clk_oe, ps2_dat_oe});
    end
  endtask
  task automatic test_parity;
    logic [9:0] bits, exp;
    logic [1:0] oe;
    logic [7:0] b;
    int inh;
    bit lat, ok;
    for (int i = 0; i < 2; i++) begin
      b = 8'(i);
      exp = model_frame(b);
      run_frame(b, 1'b1, 0, 1'b0, 8'h00, bits, inh, lat, oe, ok);
      n_tests++;
      if (!ok || bits[8] !== exp[8]) begin
        n_fail++;
        $display("FAIL parity_%02h: got par=%b ok=%0d want par=%b", b, bits[8], ok, exp[8]);
      end
    end
  endtask
  task automatic test_no_clock;
    int t = 0;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    tx_byte = PS2_CMD_ENABLE;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    while (tx_error !== 1'b1 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (t < 14998 || t > 15002) begin
      n_fail++;
      $display("FAIL noclk_timeout: got %0d cycles want ~15000", t);
    end
    n_tests++;
    if ({ps2_clk_oe, ps2_dat_oe, tx_busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL noclk_release: got oe/busy=%b want 001", {ps2_clk_oe, ps2_dat_oe, tx_busy});
    end
    @(negedge clk);
    n_tests++;
    if (tx_busy !== 1'b0 || done_cnt - d0 != 0 || err_cnt - e0 != 1) begin
      n_fail++;
      $display("FAIL noclk_end: got busy=%b done=%0d err=%0d want 0/0/1",
               tx_busy, done_cnt - d0, err_cnt - e0);
    end
  endtask
  task automatic test_no_ack;
    logic [9:0] bits;
    logic [1:0] oe;
    int inh, d0, e0;
    bit lat, ok;
    d0 = done_cnt;
    e0 = err_cnt;
    run_frame(PS2_CMD_RESET, 1'b0, 0, 1'b0, 8'h00, bits, inh, lat, oe, ok);
    n_tests++;
    if (!ok || bits !== model_frame(PS2_CMD_RESET)) begin
      n_fail++;
      $display("FAIL noack_bits: got %b ok=%0d want %b", bits, ok, model_frame(PS2_CMD_RESET));
    end
    n_tests++;
    if (done_cnt - d0 != 0 || err_cnt - e0 != 1) begin
      n_fail++;
      $display("FAIL noack_pulses: got done=%0d err=%0d want 0/1", done_cnt - d0, err_cnt - e0);
    end
  endtask
  task automatic test_reset_midframe;
    logic [9:0] bits;
    logic [1:0] oe;
    logic [7:0] b;
    int inh, d0, e0;
    bit lat, ok;
    d0 = done_cnt;
    e0 = err_cnt;
    b = 8'($urandom);
    run_frame(b, 1'b1, 5, 1'b0, 8'h00, bits, inh, lat, oe, ok);
    n_tests++;
    if (!ok || oe !== 2'b00) begin
      n_fail++;
      $display("FAIL midreset_release: got oe=%b ok=%0d want 00", oe, ok);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++;
    if (tx_busy !== 1'b0 || done_cnt - d0 != 0 || err_cnt - e0 != 0) begin
      n_fail++;
      $display("FAIL midreset_quiet: got busy=%b done=%0d err=%0d want 0/0/0",
               tx_busy, done_cnt - d0, err_cnt - e0);
    end
    b = ~b;
    run_frame(b, 1'b1, 0, 1'b0, 8'h00, bits, inh, lat, oe, ok);
    n_tests++;
    if (!ok || bits !== model_frame(b) || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL midreset_restart: got %b done=%0d want %b done=1",
               bits, done_cnt - d0, model_frame(b));
    end
  endtask
  task automatic test_busy_ignore;
    logic [9:0] bits;
    logic [1:0] oe;
    logic [7:0] b1;
    int inh, d0;
    bit lat, ok;
    d0 = done_cnt;
    b1 = 8'($urandom);
    run_frame(b1, 1'b1, 0, 1'b1, b1 ^ 8'h5A, bits, inh, lat, oe, ok);
    n_tests++;
    if (!ok || bits !== model_frame(b1)) begin
      n_fail++;
      $display("FAIL busy_ignore_bits: got %b want %b", bits, model_frame(b1));
    end
    n_tests++;
    if (done_cnt - d0 != 1 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore_done: got done=%0d busy=%b want 1/0", done_cnt - d0, tx_busy);
    end
  endtask
  task automatic test_random;
    logic [9:0] bits;
    logic [1:0] oe;
    logic [7:0] b;
    int inh, d0, e0;
    bit lat, ok;
    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      b = 8'($urandom);
      run_frame(b, 1'b1, 0, 1'b0, 8'h00, bits, inh, lat, oe, ok);
      n_tests++;
      if (!ok || bits !== model_frame(b) || done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
        n_fail++;
        $display("FAIL random_%02h: got %b done=%0d err=%0d want %b done=1 err=0",
                 b, bits, done_cnt - d0, err_cnt - e0, model_frame(b));
      end
    end
  endtask
  initial begin
    test_reset;
    test_setled;
    test_parity;
    test_no_clock;
    test_no_ack;
    test_reset_midframe;
    test_busy_ignore;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
